// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO stream reader: occupancy encoding and default sizes.
package fifo_stream_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CW    = 16;

  // Occupancy of the 2-entry output buffer; the encoding 3 is never produced.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry in-order buffer: e0 is the head presented downstream, e1 the overflow slot.
// push writes the first free slot after any pop shift; flush empties it.
module skid_buffer2
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output occ_e             occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] e0, e1;
  logic [WIDTH-1:0] e0_next, e1_next;
  occ_e             occ_next;

  assign head = e0;

  // Next occupancy and slot contents from push/pop/flush.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    occ_next = occ;
    e0_next  = e0;
    e1_next  = e1;
    if (flush) begin
      occ_next = OCC_EMPTY;
    end else begin
      occ_next = occ_e'(occ + {1'b0, push} - {1'b0, pop});
      if (pop && occ == OCC_TWO) e0_next = e1;
      if (push) begin
        if (occ_next == OCC_ONE) e0_next = push_data;
        else                     e1_next = push_data;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      occ <= OCC_EMPTY;
      // NOTE: the data slots are reset too, so out_data is a known zero after reset.
      e0  <= '0;
      e1  <= '0;
    end else begin
      occ <= occ_next;
      e0  <= e0_next;
      e1  <= e1_next;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a show-ahead FIFO: pops only when legal and room exists,
// presents words as a valid/ready stream and counts completed transfers (saturating).
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = DEFAULT_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    word_count
);

  occ_e occ;
  logic xfer;

  // Pop depends only on registered occupancy, never on out_ready, so there is no
  // combinational path from the downstream handshake back into the FIFO.
  assign fifo_pop  = rst & ~flush & ~fifo_empty & (occ != OCC_TWO);
  assign out_valid = (occ != OCC_EMPTY);
  assign xfer      = out_valid & out_ready;

  skid_buffer2 #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_pop),
    .push_data (fifo_data),
    .pop       (xfer),
    .flush     (flush),
    .occ       (occ),
    .head      (out_data)
  );

  // Delivered-word counter; a transfer in a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_count <= '0;
    end else if (xfer && word_count != {CW{1'b1}}) begin
      word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a queue-based FIFO feeds two reader instances (CW=16 and CW=4);
// a queue model of the buffered words predicts pop, valid, data and counts each cycle.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst, fifo_empty, out_ready, flush;
  logic [7:0]  fifo_data;
  logic        fifo_pop, out_valid;
  logic [7:0]  out_data;
  logic [15:0] word_count;
  logic        pop4, valid4;
  logic [7:0]  data4;
  logic [3:0]  wc4;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .word_count(word_count)
  );

  fifo_stream_reader #(.WIDTH(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(pop4), .out_valid(valid4), .out_data(data4),
    .out_ready(out_ready), .flush(flush), .word_count(wc4)
  );

  bit [7:0] fq[$];   // words waiting in the upstream FIFO
  bit [7:0] mq[$];   // words held by the reader, head first
  int       cnt;
  int       errors = 0;
  int       checks = 0;
  int       pops_seen;
  bit       watch77, seen77;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge; inputs already driven.
  task automatic step(input bit do_check);
    bit       ep, ev, x;
    bit [7:0] ed, head;
    fifo_empty = (fq.size() == 0);
    head       = fifo_empty ? 8'h00 : fq[0];
    fifo_data  = head;
    #1;
    ev = (mq.size() > 0);
    ed = ev ? mq[0] : 8'h00;
    ep = rst && !flush && !fifo_empty && (mq.size() < 2);
    if (do_check) begin
      check("fifo_pop", {31'd0, fifo_pop}, {31'd0, ep});
      check("out_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev) check("out_data", {24'd0, out_data}, {24'd0, ed});
      check("word_count", {16'd0, word_count}, cnt);
      check("word_count_cw4", {28'd0, wc4}, (cnt > 15) ? 15 : cnt);
    end
    if (fifo_pop) pops_seen++;
    if (watch77 && out_valid && out_ready && out_data == 8'h77) seen77 = 1'b1;
    @(posedge clk);
    x = ev && out_ready;
    if (!rst) begin
      mq.delete();
      cnt = 0;
    end else begin
      if (x && cnt < 65535) cnt++;
      if (flush) mq.delete();
      else begin
        if (x) void'(mq.pop_front());
        if (ep) mq.push_back(head);
      end
    end
    if (ep) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00;
    watch77 = 1'b0; seen77 = 1'b0; cnt = 0; pops_seen = 0;
    @(negedge clk);
    step(1'b0);                          // first edge brings the DUT out of X
    for (int i = 0; i < 3; i++) step(1'b1);  // reset held, FIFO empty
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);  // released, still empty

    // Preload 0x11,0x22,0x33 with out_ready high throughout.
    do_reset();
    fq = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1);
    check("stream3_count", {16'd0, word_count}, 3);

    // Same preload with a 5-cycle stall: exactly two pops, head holds 0x11.
    do_reset();
    fq = '{8'h11, 8'h22, 8'h33};
    pops_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b1);
    check("stall_pops", pops_seen, 2);
    check("stall_head", {24'd0, out_data}, 32'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1);

    // Two words buffered, flush with out_ready low, then 0x66 follows.
    do_reset();
    fq = '{8'h44, 8'h55};
    for (int i = 0; i < 3; i++) step(1'b1);
    flush = 1'b1;
    step(1'b1);
    flush = 1'b0;
    check("flush_count_held", {16'd0, word_count}, 0);
    fq.push_back(8'h66);
    step(1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);

    // Saturation of the 4-bit counter across 20 words, then more transfers.
    do_reset();
    for (int i = 0; i < 20; i++) fq.push_back(8'(i + 1));
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) step(1'b1);
    check("sat_cw4", {28'd0, wc4}, 15);
    check("count_cw16_20", {16'd0, word_count}, 20);
    fq = '{8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 5; i++) step(1'b1);
    check("sat_cw4_hold", {28'd0, wc4}, 15);

    // Randomized traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0 && fq.size() < 8) fq.push_back(8'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step(1'b1);
    end
    flush = 1'b0;

    // Reset while 0x77 is buffered: it must never be delivered.
    do_reset();
    fq = '{8'h77};
    step(1'b1);
    step(1'b1);
    check("pre_reset_head", {24'd0, out_data}, 32'h77);
    watch77 = 1'b1;
    rst = 1'b0;
    step(1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    check("reset_valid", {31'd0, out_valid}, 0);
    check("reset_count", {16'd0, word_count}, 0);
    fq.push_back(8'h88);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("no_77_delivered", {31'd0, seen77}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the shift-register FIFO.
- Issues pop only when legal (never pops an empty FIFO) and captures show-ahead head data into a 2-entry output buffer.
- Presents the data as a valid/ready stream, preserving order, at a sustained rate of 1 word/cycle.
- Counts delivered words, so scoreboards and formal tops can check pop-side integrity and liveness.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- CW, 16, width of the delivered-word counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset asserted), sampled on rising clk.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO head word; valid in the same cycle whenever fifo_empty=0 (show-ahead).
- fifo_pop  out  1  pop request to the FIFO; combinational.
- out_valid  out  1  output stream valid.
- out_data  out  WIDTH  output stream data.
- out_ready  in  1  downstream accept.
- flush  in  1  discard the buffered words; no pop this cycle.
- word_count  out  CW  number of completed out transfers, saturating.

Behaviour:
- State: occupancy occ in {EMPTY=0, ONE=1, TWO=2}, plus buffer entries e0 (head) and e1. occ=3 is unreachable; the verifier asserts this.
- Combinational pop:
  - fifo_pop = rst & ~flush & ~fifo_empty & (occ != TWO).
  - fifo_pop is never 1 while fifo_empty=1. This is the pop-side legality invariant and is asserted in formal.
- Transfer: xfer = out_valid & out_ready.
- Outputs:
  - out_valid = (occ != EMPTY).
  - out_data = e0. When occ=EMPTY, out_data holds its last value; it is not checked.
- Next-state, when rst=1 and flush=0:
  - occ' = occ + fifo_pop - xfer.
  - On fifo_pop, fifo_data is written to the first free slot after the xfer shift: e0 if occ'=1, e1 if occ'=2.
  - On xfer with occ=TWO, e1 moves to e0.
- Latency: a word visible at the FIFO head with occ=EMPTY appears on out_data with out_valid=1 in the next cycle (1 cycle).
- Throughput:
  - In steady state with out_ready=1, occ stays at ONE, and pop and xfer fire every cycle.
  - From occ=TWO, pop resumes one cycle after the first xfer.
- Stall: while out_valid=1 and out_ready=0, out_data and e0 must not change; the verifier asserts stability.
- Ordering: words leave in exactly the order popped. No drop and no duplication, except on flush.
- flush=1 (and rst=1):
  - occ' = EMPTY; fifo_pop = 0.
  - Any xfer occurring in the flush cycle still counts.
  - Buffered words are discarded.
- word_count:
  - Increments by 1 on each xfer.
  - Saturates at 2^CW-1 and does not wrap.
- Simultaneous events:
  - pop+xfer at occ=ONE: occ stays ONE, e0 = new word.
  - pop+xfer at occ=EMPTY is impossible, since out_valid=0.
- Reset (rst=0):
  - Next edge: occ=EMPTY, out_valid=0, word_count=0, e0/e1 = 0.
  - fifo_pop = 0 combinationally while rst=0.
  - Mid-operation reset discards buffered data. The FIFO is reset by the same rst net.
- out_ready may toggle arbitrarily; no combinational path from out_ready to fifo_pop.

Decomposition:
- Shared package fifo_stream_pkg holds:
  - occupancy encoding constants OCC_EMPTY/OCC_ONE/OCC_TWO;
  - the default WIDTH/CW constants.
- One natural sub-module, skid_buffer2: the 2-entry buffer with occ, e0/e1, push/pop/flush.
- fifo_stream_reader adds the pop gating and word_count around it.

Test Plan:
- Reset pulled low then high, FIFO empty -> out_valid=0, fifo_pop=0, word_count=0 for 3 cycles.
- FIFO preloaded with 0x11,0x22,0x33, out_ready=1 throughout:
  - out_data = 0x11,0x22,0x33 on 3 consecutive cycles starting 1 cycle after reset release;
  - word_count=3; fifo_pop never 1 while empty.
- Same preload, out_ready=0 for 5 cycles then 1:
  - exactly 2 pops occur, occ=TWO, out_data holds 0x11 stable;
  - after release, 0x11,0x22,0x33 arrive in order with no gaps.
- occ=TWO holding 0x44,0x55, flush=1 with out_ready=0 for one cycle:
  - next cycle out_valid=0; no pop during the flush cycle; word_count unchanged;
  - subsequent FIFO word 0x66 is delivered next.
- CW=4, 20 words streamed -> word_count=15 (saturated), still 15 after further transfers.
- rst driven low while occ=ONE holding 0x77 -> next edge out_valid=0, word_count=0; 0x77 is never delivered.
